axi_probe_master: RTL

AXI_PROBE_MASTER -- requirements
Module: axi_probe_master

---
 rtl/axi_probe_pkg.sv | 17 +
 rtl/axi_probe_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_probe_pkg.sv
// Shared FSM state codes and AXI burst/response encodings for axi_probe_master.
package axi_probe_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AR   = 3'd1;
   localparam logic [2:0] ST_R    = 3'd2;
   localparam logic [2:0] ST_AWW  = 3'd3;
   localparam logic [2:0] ST_B    = 3'd4;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_probe_master.sv
// AXI4 probe master: issues one INCR write or read burst per command and reports status.
// Define AXIPROBE_RDCHECK_EN to compare read data against the seed+beat pattern.
module axi_probe_master
   import axi_probe_pkg::*;
#(
   parameter int C_AXI_ID_WIDTH   = 2,
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 6
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic                          i_cmd_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [7:0]                    i_cmd_len,
   input  logic [C_AXI_ID_WIDTH-1:0]     i_cmd_id,
   input  logic [C_AXI_DATA_WIDTH-1:0]   i_cmd_seed,
   output logic                          o_busy,
   output logic                          o_done,
   output logic [1:0]                    o_resp,
   output logic                          o_proto_err,
   output logic [8:0]                    o_beats,
   output logic [8:0]                    o_mismatch,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
   output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [7:0]                    M_AXI_AWLEN,
   output logic [2:0]                    M_AXI_AWSIZE,
   output logic [1:0]                    M_AXI_AWBURST,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                          M_AXI_WLAST,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   input  logic [C_AXI_ID_WIDTH-1:0]     M_AXI_BID,
   input  logic [1:0]                    M_AXI_BRESP,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
   output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   input  logic [C_AXI_ID_WIDTH-1:0]     M_AXI_RID,
   input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic                          M_AXI_RLAST,
   input  logic [1:0]                    M_AXI_RRESP
);

   localparam int DW = C_AXI_DATA_WIDTH;
   localparam logic [2:0] AXSIZE = 3'($clog2(DW/8));

   function automatic logic [8:0] sat_inc(input logic [8:0] v);
      return (v == 9'h1FF) ? v : v + 9'd1;
   endfunction

   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [2:0]                  state;
   logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr;
   logic [7:0]                  cmd_len;
   logic [C_AXI_ID_WIDTH-1:0]   cmd_id;
   logic [DW-1:0]               cmd_seed;
   logic [7:0]                  wcnt;
   logic                        aw_done, w_done;
   logic                        awvalid, wvalid, arvalid;
   logic [8:0]                  beats;
   logic [1:0]                  resp;
   logic                        proto_err, done;
   logic                        accept, aw_hs, w_hs, w_last, r_err;

   assign accept = (state == ST_IDLE) && i_cmd_valid;
   assign w_last = (wcnt == cmd_len);
   assign aw_hs  = awvalid && M_AXI_AWREADY;
   assign w_hs   = wvalid && M_AXI_WREADY;

   // A read beat is bad on ID mismatch, RLAST misplaced, or running past len+1 beats.
   assign r_err = (M_AXI_RID != cmd_id)
                || (M_AXI_RLAST != (beats == {1'b0, cmd_len}))
                || (!M_AXI_RLAST && (beats > {1'b0, cmd_len}));

   // Command payload needs no reset: it is only consumed once a command is accepted.
   always_ff @(posedge S_AXI_ACLK) begin
      if (accept) begin
         cmd_addr <= i_cmd_addr;
         cmd_len  <= i_cmd_len;
         cmd_id   <= i_cmd_id;
         cmd_seed <= i_cmd_seed;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state     <= ST_IDLE;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         arvalid   <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         wcnt      <= 8'd0;
         beats     <= 9'd0;
         resp      <= RESP_OKAY;
         proto_err <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  beats     <= 9'd0;
                  resp      <= RESP_OKAY;
                  proto_err <= 1'b0;
                  wcnt      <= 8'd0;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  if (i_cmd_we) begin
                     state   <= ST_AWW;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                  end else begin
                     state   <= ST_AR;
                     arvalid <= 1'b1;
                  end
               end
            end
            ST_AWW: begin
               if (aw_hs) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  beats <= sat_inc(beats);
                  if (w_last) begin
                     wvalid <= 1'b0;
                     w_done <= 1'b1;
                  end else begin
                     wcnt <= wcnt + 8'd1;
                  end
               end
               if ((aw_done || aw_hs) && (w_done || (w_hs && w_last)))
                  state <= ST_B;
            end
            ST_B: begin
               if (M_AXI_BVALID) begin
                  resp      <= M_AXI_BRESP;
                  proto_err <= (M_AXI_BID != cmd_id);
                  state     <= ST_IDLE;
                  done      <= 1'b1;
               end
            end
            ST_AR: begin
               if (M_AXI_ARREADY) begin
                  arvalid <= 1'b0;
                  state   <= ST_R;
               end
            end
            ST_R: begin
               if (M_AXI_RVALID) begin
                  beats <= sat_inc(beats);
                  resp  <= resp_max(resp, M_AXI_RRESP);
                  if (r_err)
                     proto_err <= 1'b1;
                  if (M_AXI_RLAST) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef AXIPROBE_RDCHECK_EN
   logic [8:0]    mismatch;
   logic [DW-1:0] r_expect;

   assign r_expect = cmd_seed + DW'(beats);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN)
         mismatch <= 9'd0;
      else if (accept)
         mismatch <= 9'd0;
      else if ((state == ST_R) && M_AXI_RVALID && (M_AXI_RDATA != r_expect))
         mismatch <= sat_inc(mismatch);
   end

   assign o_mismatch = mismatch;
`else
   logic rdata_unused;
   assign rdata_unused = ^M_AXI_RDATA;
   assign o_mismatch   = 9'd0;
`endif

   assign o_cmd_ready   = (state == ST_IDLE);
   assign o_busy        = (state != ST_IDLE);
   assign o_done        = done;
   assign o_resp        = resp;
   assign o_proto_err   = proto_err;
   assign o_beats       = beats;

   assign M_AXI_AWVALID = awvalid;
   assign M_AXI_AWID    = cmd_id;
   assign M_AXI_AWADDR  = cmd_addr;
   assign M_AXI_AWLEN   = cmd_len;
   assign M_AXI_AWSIZE  = AXSIZE;
   assign M_AXI_AWBURST = BURST_INCR;
   assign M_AXI_WVALID  = wvalid;
   assign M_AXI_WDATA   = cmd_seed + DW'(wcnt);
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WLAST   = w_last;
   assign M_AXI_BREADY  = (state == ST_B);
   assign M_AXI_ARVALID = arvalid;
   assign M_AXI_ARID    = cmd_id;
   assign M_AXI_ARADDR  = cmd_addr;
   assign M_AXI_ARLEN   = cmd_len;
   assign M_AXI_ARSIZE  = AXSIZE;
   assign M_AXI_ARBURST = BURST_INCR;
   assign M_AXI_RREADY  = (state == ST_R);

endmodule
